// File: rtl/fft_usb_pkg.sv
// Shared definitions for the FFT <-> FX2 USB datapath (input side and result serializer).
package fft_usb_pkg;

  localparam int WORD_W = 16;

  // FX2 slave-FIFO endpoint selects seen on fx2_a
  localparam logic [1:0] EP_OUT_ADDR = 2'b00;
  localparam logic [1:0] EP_IN_ADDR  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WRITE,
    PKTEND,
    DONE
  } state_t;

  // 16-bit words in one frame of 2**npoint complex samples
  function automatic int nwords(input int npoint);
    return 2 ** (npoint + 1);
  endfunction

endpackage

// File: rtl/fx2_wr_strobe.sv
// FX2 slave-FIFO write strobe: registered slwr_n plus the accept flag for the edge where
// the FIFO takes the word. A refused word (full_n low) stays put and slwr_n backs off.
module fx2_wr_strobe (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic full_n,
  output logic slwr_n,
  output logic accept
);

  assign accept = ~slwr_n & full_n;

  always_ff @(posedge clk) begin
    if (rst) slwr_n <= 1'b1;
    else     slwr_n <= ~(arm & full_n);
  end

endmodule

// File: rtl/fft_dout_serializer.sv
// Drains one FFT result frame into the FX2 IN FIFO as 16-bit words (real/imag interleaved).
//   state  | meaning
//   IDLE   | waiting for fft_dout_valid, frame captured on it
//   REQ    | bus_req high, waiting for bus_gnt (also after a grant loss)
//   WRITE  | streaming words, one per accepted slwr_n strobe
//   PKTEND | commit the short packet once FIFO has room and bus is owned
//   DONE   | single cycle, frame_done high, release bus and busy
module fft_dout_serializer
  import fft_usb_pkg::*;
#(
  parameter int         NPOINT    = 3,
  parameter logic [1:0] EP_ADDR   = EP_IN_ADDR,
  parameter bit         PKTEND_EN = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fft_dout_valid,
  output logic                            fft_dout_busy,
  input  logic [WORD_W*(2**NPOINT)-1:0]   fft_dout_real,
  input  logic [WORD_W*(2**NPOINT)-1:0]   fft_dout_imag,
  output logic                            bus_req,
  input  logic                            bus_gnt,
  input  logic                            fx2_full_n,
  output logic                            fx2_slwr_n,
  output logic                            fx2_pktend_n,
  output logic [1:0]                      fx2_a,
  output logic [WORD_W-1:0]               fx2_dout,
  output logic                            fx2_dout_oe,
  output logic                            frame_done,
  output logic [15:0]                     frame_count
);

  localparam int              NSAMP    = 2 ** NPOINT;
  localparam int              IW       = NPOINT + 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(nwords(NPOINT) - 1);

  state_t              state;
  logic [IW-1:0]       word_idx;
  logic [IW-1:0]       idx_inc;
  logic [WORD_W-1:0]   real_buf [NSAMP];
  logic [WORD_W-1:0]   imag_buf [NSAMP];
  logic [WORD_W-1:0]   word_cur;
  logic [WORD_W-1:0]   word_nxt;
  logic                capture;
  logic                last_word;
  logic                accept;
  logic                arm;

  assign idx_inc   = word_idx + IW'(1);
  assign word_cur  = word_idx[0] ? imag_buf[word_idx[IW-1:1]] : real_buf[word_idx[IW-1:1]];
  assign word_nxt  = idx_inc[0]  ? imag_buf[idx_inc[IW-1:1]]  : real_buf[idx_inc[IW-1:1]];
  assign capture   = ~rst & (state == IDLE) & fft_dout_valid;
  assign last_word = (word_idx == LAST_IDX);

  // Keep strobing only while owned and words remain after this edge's accept.
  assign arm = bus_gnt & ((state == REQ) | ((state == WRITE) & ~(accept & last_word)));

  fx2_wr_strobe u_strobe (
    .clk    (clk),
    .rst    (rst),
    .arm    (arm),
    .full_n (fx2_full_n),
    .slwr_n (fx2_slwr_n),
    .accept (accept)
  );

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < NSAMP; k++) begin
        real_buf[k] <= fft_dout_real[k*WORD_W +: WORD_W];
        imag_buf[k] <= fft_dout_imag[k*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      fft_dout_busy <= 1'b0;
      bus_req       <= 1'b0;
      fx2_pktend_n  <= 1'b1;
      fx2_a         <= 2'b00;
      fx2_dout      <= '0;
      fx2_dout_oe   <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
      word_idx      <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fft_dout_valid) begin
            fft_dout_busy <= 1'b1;
            bus_req       <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus_gnt) begin
            fx2_a       <= EP_ADDR;
            fx2_dout_oe <= 1'b1;
            fx2_dout    <= word_cur;
            state       <= WRITE;
          end
        end
        WRITE: begin
          fx2_dout_oe <= bus_gnt;
          if (accept) begin
            word_idx <= idx_inc;
            fx2_dout <= word_nxt;
          end
          if (accept && last_word) begin
            if (PKTEND_EN) begin
              state <= PKTEND;
            end else begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              state       <= DONE;
            end
          end else if (!bus_gnt) begin
            state <= REQ;
          end
        end
        PKTEND: begin
          fx2_dout_oe <= bus_gnt;
          if (bus_gnt && fx2_full_n) begin
            fx2_pktend_n <= 1'b0;
            frame_done   <= 1'b1;
            frame_count  <= frame_count + 16'd1;
            state        <= DONE;
          end
        end
        DONE: begin
          fx2_pktend_n  <= 1'b1;
          fft_dout_busy <= 1'b0;
          bus_req       <= 1'b0;
          fx2_dout_oe   <= 1'b0;
          fx2_a         <= 2'b00;
          fx2_dout      <= '0;
          word_idx      <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fft_dout_serializer.md
Name: fft_dout_serializer

Overview:
- Downstream stage of the FFT core; drains one complete FFT result frame toward the host.
- Accepts one frame per fft_dout_valid/fft_dout_busy handshake, holding 2**NPOINT complex samples, each with 16-bit real and 16-bit imag parts.
- Serializes the frame into 16-bit words and writes them into the FX2 slave-FIFO IN endpoint.
- Shares the fx2_db bus with the input path through a simple req/gnt arbiter.

Parameters:
- NPOINT, 3: log2 of FFT size; the frame holds 2**NPOINT complex samples, i.e. 2**(NPOINT+1) words.
- EP_ADDR, 2'b10: value driven on fx2_a while this block owns the bus (IN endpoint FIFO select).
- PKTEND_EN, 1: 1 = commit a short packet with PKTEND after the last word of each frame; 0 = never assert PKTEND.

Ports:
- clk  in  1  system clock (FX2 IFCLK domain)
- rst  in  1  synchronous, active-high reset
- fft_dout_valid  in  1  result frame available on fft_dout_real/imag
- fft_dout_busy  out  1  high while a frame is held or being sent; upstream may only present a new frame while this is low
- fft_dout_real  in  16*(2**NPOINT)  real parts; sample k occupies bits [16k+15:16k]
- fft_dout_imag  in  16*(2**NPOINT)  imag parts, same packing
- bus_req  out  1  request ownership of fx2_db/fx2_a
- bus_gnt  in  1  ownership granted; may drop at any cycle
- fx2_full_n  in  1  FX2 IN FIFO not-full flag (1 = space available)
- fx2_slwr_n  out  1  slave-FIFO write strobe, active low
- fx2_pktend_n  out  1  packet-end strobe, active low
- fx2_a  out  2  FIFO address
- fx2_dout  out  16  write data toward the fx2_db tristate
- fx2_dout_oe  out  1  enables the fx2_db driver
- frame_done  out  1  one-cycle pulse when a frame is fully committed
- frame_count  out  16  frames completed since reset; wraps at 2**16

Behaviour:
- Reset (rst=1 sampled at a clk edge) forces these values; any in-progress frame is discarded and no partial PKTEND is issued:
  - state=IDLE
  - fft_dout_busy=0, bus_req=0
  - fx2_slwr_n=1, fx2_pktend_n=1
  - fx2_a=2'b00, fx2_dout=0, fx2_dout_oe=0
  - frame_done=0, frame_count=0, word index=0
- All outputs are registered.
- Capture rule:
  - In IDLE, a cycle with fft_dout_valid=1 latches both vectors into internal buffers.
  - fft_dout_busy=1 from the next cycle; state becomes REQ.
  - fft_dout_valid while busy=1 is ignored; no capture, no overwrite.
- Word order: word 2k = real[k], word 2k+1 = imag[k], for k = 0 .. 2**NPOINT-1. The word index counter is NPOINT+1 bits wide.
- States:
  - IDLE: waiting for a frame.
  - REQ: bus_req=1; wait for bus_gnt.
  - WRITE: stream the frame words.
  - PKTEND: commit a short packet.
  - DONE: one cycle; frame_done=1, frame_count+1, busy->0, bus_req->0, oe->0, then IDLE.
- REQ -> WRITE on bus_gnt=1. From the next cycle: fx2_a=EP_ADDR, fx2_dout_oe=1, fx2_dout=word[index].
- WRITE transfer rule:
  - A word is accepted at an edge where fx2_slwr_n=0 and fx2_full_n=1. On acceptance, index+1 and fx2_dout advances.
  - fx2_slwr_n=0 is driven for the next cycle only if bus_gnt=1, fx2_full_n=1, and words remain.
  - If fx2_full_n=0 at an edge where fx2_slwr_n=0: no accept, the same word is held, fx2_slwr_n returns to 1 until full_n recovers. Words are never dropped or duplicated.
- bus_gnt drop in WRITE:
  - fx2_slwr_n=1 and fx2_dout_oe=0 next cycle.
  - Index is held; state goes to REQ.
  - On re-grant, streaming resumes at the same word.
- After the last word (index 2**(NPOINT+1)-1) is accepted:
  - PKTEND_EN=1: go to PKTEND. Assert fx2_pktend_n=0 for exactly one cycle once fx2_full_n=1 and bus_gnt=1, then go to DONE.
  - PKTEND_EN=0: go directly to DONE.
- Index wraps to 0 at DONE.
- fx2_slwr_n and fx2_pktend_n are never low in the same cycle, and never low while fx2_dout_oe=0.
- Throughput: with gnt and full_n held high, one word per cycle; a frame takes 2**(NPOINT+1) write cycles plus 2 (REQ, first drive) plus PKTEND/DONE.
- Minimum IDLE-capture to busy=0 (NPOINT=3, PKTEND_EN=1, gnt already high): 1+1+16+1+1 = 20 cycles.

Decomposition:
- Shared package fft_usb_pkg:
  - state enum (IDLE, REQ, WRITE, PKTEND, DONE)
  - WORD_W=16
  - function nwords(NPOINT)
  - default EP addresses, shared with the input-side interface
- One sub-module: fx2_wr_strobe, holding the slwr/full_n accept-and-hold logic; reusable by other FX2 write paths. Word mux and FSM stay in the top.

Test Plan:
- Reset then single frame (NPOINT=3), real[k]=16'h1000+k, imag[k]=16'h2000+k, gnt=1, full_n=1 -> accepted words in order 1000,2000,1001,2001,…,1007,2007; one pktend_n pulse after word 15; frame_done one cycle; frame_count=1; busy low at cycle 20.
- fx2_full_n forced 0 for 5 cycles while word 6 is driven -> word 6 (16'h1003) held and accepted exactly once after recovery; total accepted = 16; no duplicates.
- bus_gnt dropped after word 9 accepted, restored 7 cycles later -> oe=0 and slwr_n=1 during the gap; resume at word 10 (16'h1005); no extra PKTEND.
- fft_dout_valid pulsed again mid-frame with different data -> ignored; output still matches first frame; second frame captured only after busy returns 0.
- rst asserted at word 4 -> all outputs at reset values next cycle; no pktend_n pulse; frame_count=0; a fresh frame then completes normally.
- PKTEND_EN=0, two back-to-back frames -> pktend_n never asserted; frame_count=2; second capture occurs the cycle after busy falls.
